// File: rtl/host_arb_pkg.sv
// host_arb_pkg: shared widths, abort read-data pattern and arbiter FSM states.
package host_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_req
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] start;
  logic [N-1:0]  rot;
  // A start of N (non power-of-two wrap) shifts the doubled vector by N, which is the same as 0.
  assign start = last + IW'(1);
  assign rot = N'({req, req} >> start);
  assign any_req = |req;
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) winner = IW'((int'(start) + k) % N);
  end
endmodule

// File: rtl/host_bus_arbiter.sv
// host_bus_arbiter: round-robin sharing of the host memory port between NUM_REQ masters.
// Define HOST_ARB_TIMEOUT_EN to enable the downstream watchdog (TIMEOUT_CYCLES).
module host_bus_arbiter
  import host_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      host_valid,
  input  logic                      host_ready,
  output logic [ADDR_W-1:0]         host_addr,
  output logic [DATA_W-1:0]         host_wdata,
  output logic [STRB_W-1:0]         host_wstrb,
  input  logic [DATA_W-1:0]         host_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("host_bus_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     winner;
  logic              any_req;
  logic              tmo;
  logic              done;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .winner  (winner),
    .any_req (any_req)
  );
`ifdef HOST_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == ARB_IDLE) ? '0 : cnt_q + CW'(1);
  assign tmo = state_q == ARB_BUSY && cnt_q == CW'(TIMEOUT_CYCLES - 1) && !host_ready;
  always_ff @(posedge sys_clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  // Gated by rst so a transaction lost to reset never signals completion.
  assign done = !rst && state_q == ARB_BUSY && (host_ready || tmo);
  assign timeout_err = done && !host_ready;
  assign req_ready = done ? NUM_REQ'(1) << grant_q : '0;
  assign req_rdata = !done ? '0 : host_ready ? host_rdata : TIMEOUT_RDATA;
  assign host_valid = state_q == ARB_BUSY;
  assign busy = state_q == ARB_BUSY;
  assign host_addr = addr_q;
  assign host_wdata = wdata_q;
  assign host_wstrb = strb_q;
  assign grant_idx = grant_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    grant_d = grant_q;
    last_d = last_q;
    if (state_q == ARB_IDLE && any_req) begin
      state_d = ARB_BUSY;
      addr_d = req_addr[{winner, 5'd0} +: ADDR_W];
      wdata_d = req_wdata[{winner, 5'd0} +: DATA_W];
      strb_d = req_wstrb[{winner, 2'd0} +: STRB_W];
      grant_d = winner;
    end else if (done) begin
      state_d = ARB_IDLE;
      last_d = grant_q;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      grant_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_host_bus_arbiter.sv
// tb_host_bus_arbiter: random + directed traffic against a transaction-level reference model with a response scoreboard.
module tb_host_bus_arbiter;
  localparam int N = 2;
  localparam int T = 8;
`ifdef HOST_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_wstrb = '0;
  logic [31:0]     req_rdata;
  logic            host_valid;
  logic            host_ready = 1'b0;
  logic [31:0]     host_addr;
  logic [31:0]     host_wdata;
  logic [3:0]      host_wstrb;
  logic [31:0]     host_rdata = '0;
  logic [0:0]      grant_idx;
  logic            busy;
  logic            timeout_err;

  host_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_rdata(req_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_rdata(host_rdata),
    .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {int idx; logic [31:0] rdata; bit tmo;} rsp_t;
  rsp_t exp_q[$];
  int   grant_log[$];
  int   cmp = 0;
  int   bad = 0;
  int   tmo_seen = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus state: per-requester outstanding flag, responder latency control.
  logic [N-1:0] active = '0;
  bit           gen_en = 0;
  int           reissue_pct = 30;
  int           fix_lat = -1;
  bit           use_fix_rdata = 0;
  logic [31:0]  fix_rdata = '0;
  bit           lat_set = 0;
  int           lat = 0;
  int           kk = 0;

  task automatic new_cmd(int i, logic [31:0] a, logic [31:0] w, logic [3:0] s);
    active[i] = 1'b1;
    req_valid[i] = 1'b1;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = w;
    req_wstrb[i*4 +: 4] = s;
  endtask

  task automatic step();
    logic [N-1:0] ack;
    bit hv, hr;
    @(negedge sys_clk);
    ack = req_ready;
    hv = host_valid;
    hr = host_ready;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        active[i] = 1'b0;
        req_valid[i] = 1'b0;
      end
      if (!active[i] && gen_en && $urandom_range(99) < reissue_pct)
        new_cmd(i, $urandom, $urandom, $urandom_range(1) ? 4'($urandom) : 4'h0);
    end
    if (hv && !hr) begin
      if (!lat_set) begin
        lat_set = 1;
        kk = 0;
        lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(TMO_EN ? T + 2 : 4, 1));
      end
      kk++;
      host_ready = (kk == lat);
      if (host_ready) host_rdata = use_fix_rdata ? fix_rdata : $urandom;
    end else begin
      lat_set = 0;
      host_ready = 1'b0;
    end
  endtask

  // Reference model: at most one outstanding transaction, chosen by scanning
  // requesters from one past the last winner; it completes on host_ready, or
  // aborts in its T-th busy cycle when the watchdog is built in.
  int          m_busy = 0;
  int          m_last = N - 1;
  int          m_grant = 0;
  int          m_k = 0;
  bit          found = 0;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_strb;
  initial forever begin
    @(negedge sys_clk);
    if (rst) begin
      m_busy = 0;
      m_last = N - 1;
    end else begin
      check("busy_vs_valid", busy, host_valid);
      if (m_busy == 0) begin
        check("host_valid_idle", host_valid, 0);
        if (req_valid != '0) begin
          found = 0;
          for (int k = 1; k <= N; k++)
            if (!found && req_valid[(m_last + k) % N]) begin
              m_grant = (m_last + k) % N;
              found = 1;
            end
          e_addr = req_addr[m_grant*32 +: 32];
          e_wdata = req_wdata[m_grant*32 +: 32];
          e_strb = req_wstrb[m_grant*4 +: 4];
          grant_log.push_back(m_grant);
          m_busy = 1;
          m_k = 0;
        end
      end else begin
        check("host_valid_busy", host_valid, 1);
        check("grant_idx", grant_idx, m_grant);
        check("host_addr", host_addr, e_addr);
        check("host_wdata", host_wdata, e_wdata);
        check("host_wstrb", host_wstrb, e_strb);
        if (host_ready) begin
          exp_q.push_back('{m_grant, host_rdata, 1'b0});
          m_busy = 0;
          m_last = m_grant;
        end else if (TMO_EN && m_k == T - 1) begin
          exp_q.push_back('{m_grant, 32'hDEAD_BEEF, 1'b1});
          m_busy = 0;
          m_last = m_grant;
        end else m_k++;
      end
    end
  end

  rsp_t mon_r;
  initial forever begin
    @(negedge sys_clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_r = exp_q.pop_front();
      check("req_ready", req_ready, 1 << mon_r.idx);
      check("req_rdata", req_rdata, mon_r.rdata);
      check("timeout_err", timeout_err, mon_r.tmo);
    end else check("no_response", {req_ready, timeout_err}, 0);
    if (timeout_err) tmo_seen++;
  end

  task automatic drain();
    gen_en = 0;
    for (int c = 0; c < 200 && active != '0; c++) step();
    check("drain_done", active, 0);
    repeat (2) step();
  endtask

  int t0;
  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_host_valid", host_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_req_rdata", req_rdata, 0);
    check("rst_grant_idx", grant_idx, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_host_addr", host_addr, 0);
    check("rst_host_wstrb", host_wstrb, 0);
    @(posedge sys_clk);
    #1 rst = 1'b0;
    step();
    // requester 0 read of 0x10 answered with a fixed word
    fix_lat = 2;
    use_fix_rdata = 1;
    fix_rdata = 32'h1234_5678;
    new_cmd(0, 32'h0000_0010, 32'h0, 4'h0);
    repeat (6) step();
    // requester 1 full-word write
    fix_lat = 1;
    new_cmd(1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF);
    repeat (5) step();
    // both requesters saturating: grants must alternate
    use_fix_rdata = 0;
    grant_log.delete();
    gen_en = 1;
    reissue_pct = 100;
    repeat (16) step();
    drain();
    check("alt_count", grant_log.size() >= 4, 1);
    for (int i = 1; i < grant_log.size(); i++)
      check("alternate", grant_log[i], 1 - grant_log[i-1]);
    // random traffic
    fix_lat = -1;
    reissue_pct = 30;
    gen_en = 1;
    repeat (3000) step();
    drain();
    // reset while busy
    fix_lat = 5;
    new_cmd(1, 32'h0000_0030, 32'h0, 4'h0);
    repeat (3) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    active = '0;
    req_valid = '0;
    host_ready = 1'b0;
    lat_set = 0;
    @(negedge sys_clk);
    check("post_rst_host_valid", host_valid, 0);
    check("post_rst_busy", busy, 0);
    @(posedge sys_clk);
    #1;
    grant_log.delete();
    fix_lat = 1;
    new_cmd(0, 32'h0000_0040, 32'h0, 4'h0);
    new_cmd(1, 32'h0000_0044, 32'h0, 4'h0);
    repeat (8) step();
    check("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : 99, 0);
    drain();
`ifdef HOST_ARB_TIMEOUT_EN
    // never answered: abort in the T-th busy cycle
    t0 = tmo_seen;
    fix_lat = 100;
    new_cmd(0, 32'h0000_0050, 32'h0, 4'h0);
    repeat (T + 4) step();
    check("timeout_pulses", tmo_seen - t0, 1);
    // answered exactly in the abort cycle: normal completion wins
    t0 = tmo_seen;
    fix_lat = T - 1;
    use_fix_rdata = 1;
    fix_rdata = 32'hCAFE_0001;
    new_cmd(1, 32'h0000_0060, 32'h0, 4'h0);
    repeat (T + 4) step();
    check("late_ready_no_timeout", tmo_seen - t0, 0);
    drain();
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule
